// File: rtl/secp256k1_mult_mod_arb.sv
// Round-robin arbiter sharing one secp256k1_mult_mod between NUM_REQ requesters, with in-order result routing.
// Define SECP256K1_MULT_ARB_STATS_EN to add per-requester issue counters and a stall-cycle counter.
module secp256k1_mult_mod_arb #(
   parameter int NUM_REQ   = 4,
   parameter int TAG_DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_REQ*256-1:0] i_req_dat_a,
   input  logic [NUM_REQ*256-1:0] i_req_dat_b,
   input  logic [NUM_REQ-1:0]     i_req_val,
   output logic [NUM_REQ-1:0]     o_req_rdy,
   output logic [255:0]           o_res_dat,
   output logic [NUM_REQ-1:0]     o_res_val,
   output logic                   o_res_err,
   input  logic [NUM_REQ-1:0]     i_res_rdy,
   output logic [255:0]           o_mul_dat_a,
   output logic [255:0]           o_mul_dat_b,
   output logic                   o_mul_val,
   output logic                   o_mul_err,
   input  logic                   i_mul_rdy,
   input  logic [255:0]           i_mul_dat,
   input  logic                   i_mul_val,
   input  logic                   i_mul_err,
   output logic                   o_mul_rdy,
`ifdef SECP256K1_MULT_ARB_STATS_EN
   output logic [NUM_REQ*32-1:0]  o_issue_cnt,
   output logic [31:0]            o_stall_cnt,
`endif
   output logic                   o_tag_err
);
   localparam int TW = $clog2(NUM_REQ);
   localparam int PW = $clog2(TAG_DEPTH);

   logic [TW-1:0] r_ptr;
   logic [TW-1:0] r_tag [TAG_DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [PW:0]   r_cnt;
   logic [255:0]  r_mul_a;
   logic [255:0]  r_mul_b;
   logic          r_mul_val;
   logic          r_tag_err;

   logic [TW:0]   w_pick;
   logic [TW-1:0] w_gnt;
   logic          w_gnt_val;
   logic [TW-1:0] w_head;
   logic          w_empty;
   logic          w_full;
   logic          w_iss_free;
   logic          w_pop;
   logic          w_acc;

   // First valid requester scanning upward from ptr; MSB of the result flags a hit.
   function automatic logic [TW:0] rr_pick(input logic [NUM_REQ-1:0] val, input logic [TW-1:0] ptr);
      int unsigned k;
      rr_pick = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = (32'(ptr) + i) % NUM_REQ;
         if (!rr_pick[TW] && val[k])
            rr_pick = {1'b1, TW'(k)};
      end
   endfunction

   assign w_pick    = rr_pick(i_req_val, r_ptr);
   assign w_gnt_val = w_pick[TW];
   assign w_gnt     = w_pick[TW-1:0];

   assign w_head     = r_tag[r_rp];
   assign w_empty    = (r_cnt == '0);
   assign w_full     = (r_cnt == (PW+1)'(TAG_DEPTH));
   assign w_iss_free = ~r_mul_val | i_mul_rdy;
   // With no tag outstanding, ready follows valid so a stray beat drains without idling ready high.
   assign o_mul_rdy  = w_empty ? i_mul_val : i_res_rdy[w_head];
   assign w_pop      = i_mul_val & o_mul_rdy & ~w_empty;
   assign w_acc      = w_gnt_val & w_iss_free & (~w_full | w_pop) & ~i_rst;

   always_comb begin
      o_req_rdy = '0;
      o_res_val = '0;
      if (w_acc)
         o_req_rdy[w_gnt] = 1'b1;
      if (i_mul_val && !w_empty && !i_rst)
         o_res_val[w_head] = 1'b1;
   end

   assign o_res_dat   = i_mul_dat;
   assign o_res_err   = i_mul_err;
   assign o_mul_dat_a = r_mul_a;
   assign o_mul_dat_b = r_mul_b;
   assign o_mul_val   = r_mul_val;
   assign o_mul_err   = 1'b0;
   assign o_tag_err   = r_tag_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr     <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_mul_val <= 1'b0;
         r_tag_err <= 1'b0;
      end else begin
         if (w_acc) begin
            r_mul_a     <= i_req_dat_a[32'(w_gnt)*256 +: 256];
            r_mul_b     <= i_req_dat_b[32'(w_gnt)*256 +: 256];
            r_mul_val   <= 1'b1;
            r_tag[r_wp] <= w_gnt;
            r_wp        <= r_wp + 1'b1;
            r_ptr       <= (w_gnt == TW'(NUM_REQ-1)) ? '0 : w_gnt + 1'b1;
         end else if (i_mul_rdy) begin
            r_mul_val <= 1'b0;
         end
         if (w_pop)
            r_rp <= r_rp + 1'b1;
         case ({w_acc, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (i_mul_val && w_empty)
            r_tag_err <= 1'b1;
      end
   end

`ifdef SECP256K1_MULT_ARB_STATS_EN
   logic [31:0] r_issue_cnt [NUM_REQ];
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++)
            r_issue_cnt[i] <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_acc)
            r_issue_cnt[w_gnt] <= r_issue_cnt[w_gnt] + 1'b1;
         if ((|i_req_val) && !w_acc)
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   always_comb begin
      o_issue_cnt = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         o_issue_cnt[i*32 +: 32] = r_issue_cnt[i];
   end
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
